// File: rtl/rv_pkg.sv
// Shared ready/valid helpers: arbiter FSM states and the round-robin pick function.
// Also used by the multi-port FIFO wrappers.
package rv_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Upper bound on requesters the pick function can search.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input int num_req,
                                         input int ptr);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            if (k < num_req && !res.found) begin
                cand = ptr + k;
                if (cand >= num_req) begin
                    cand = cand - num_req;
                end
                if (valid[cand]) begin
                    res.found = 1'b1;
                    res.idx   = RR_IDX_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_rr_arbiter_if.sv
// Bundle of the arbiter's producer-side and downstream-side ready/valid signals.
interface rv_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    // A beat moves on a rising clk edge exactly when valid and ready are both high;
    // a producer must keep valid/data/last steady until that edge, ready never waits on valid.
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          last_out;
    logic [ID_W-1:0]               src_out;
    logic                          valid_out;
    logic                          ready_out;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (
        output req_data, req_valid, req_last, ready_out,
        input  req_ready, data_out, last_out, src_out, valid_out, grant, busy
    );

    modport slave (
        input  req_data, req_valid, req_last, ready_out,
        output req_ready, data_out, last_out, src_out, valid_out, grant, busy
    );

endinterface

// File: rtl/rv_pipe_reg.sv
// Single-entry ready/valid register; accepts a new beat whenever it is empty or draining.
module rv_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    // Data only moves on an accepted beat, so it stays put while stalled or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin merge of NUM_REQ ready/valid producers onto one registered stream;
// a grant lasts one packet or MAX_BURST beats, whichever ends first.
module rv_rr_arbiter
    import rv_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic            clk,
    input  logic            rst,
    rv_rr_arbiter_if.slave  bus
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int PIPE_W = DATA_WIDTH + 1 + ID_W;

    arb_state_t             state, state_n;
    logic [ID_W-1:0]        ptr, ptr_n;
    logic [ID_W-1:0]        gnt_idx, gnt_idx_n;
    logic [CNT_W-1:0]       beat_cnt, beat_cnt_n;
    logic [NUM_REQ-1:0]     grant, grant_n;

    rr_pick_t               pick;
    logic                   slot_free;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   pipe_in_valid;
    logic                   in_xfer;
    logic                   grant_end;
    logic [PIPE_W-1:0]      pipe_out;

    always_comb begin
        pick = rr_pick(RR_MAX_REQ'(bus.req_valid), NUM_REQ, int'(ptr));
    end

    assign sel_valid     = bus.req_valid[gnt_idx];
    assign sel_last      = bus.req_last[gnt_idx];
    assign sel_data      = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    assign pipe_in_valid = (state == GRANT) && sel_valid;
    assign in_xfer       = pipe_in_valid && slot_free;
    assign grant_end     = in_xfer && (sel_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    // Only registered state and ready_out feed req_ready, never req_valid.
    assign bus.req_ready = (state == GRANT && slot_free) ? grant : '0;
    assign bus.grant     = grant;
    assign bus.busy      = (state == GRANT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            beat_cnt <= '0;
            grant    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_idx  <= gnt_idx_n;
            beat_cnt <= beat_cnt_n;
            grant    <= grant_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        gnt_idx_n  = gnt_idx;
        beat_cnt_n = beat_cnt;
        grant_n    = grant;
        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n    = GRANT;
                    gnt_idx_n  = ID_W'(pick.idx);
                    beat_cnt_n = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        grant_n[i] = (pick.idx == RR_IDX_W'(i));
                    end
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_n    = IDLE;
                    grant_n    = '0;
                    beat_cnt_n = '0;
                    // Explicit wrap keeps non-power-of-2 NUM_REQ in range.
                    ptr_n      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end else if (in_xfer) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    rv_pipe_reg #(
        .WIDTH (PIPE_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_in_valid),
        .in_ready  (slot_free),
        .in_data   ({sel_data, sel_last, gnt_idx}),
        .out_valid (bus.valid_out),
        .out_ready (bus.ready_out),
        .out_data  (pipe_out)
    );

    assign bus.data_out = pipe_out[PIPE_W-1 -: DATA_WIDTH];
    assign bus.last_out = pipe_out[ID_W];
    assign bus.src_out  = pipe_out[ID_W-1:0];

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Directed bench: a 4-requester arbiter (MAX_BURST 8) with queue-fed producers and an
// output scoreboard, plus a 3-requester arbiter (MAX_BURST 1) driven step by step.
module tb_rv_rr_arbiter;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rv_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bif4 ();
    rv_rr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(16)) bif3 ();

    rv_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .MAX_BURST(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bif4)
    );

    rv_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .MAX_BURST(1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bif3)
    );

    // producer queues {last, data} per requester, and expected output {src, last, data}
    logic [16:0] pq [4][$];
    logic [18:0] exp_q[$];
    logic [3:0]  xfer4;
    logic [3:0]  t2_grant [10];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [15:0] d, input logic l);
        pq[r].push_back({l, d});
    endtask

    task automatic expb(input int s, input logic l, input logic [15:0] d);
        exp_q.push_back({2'(s), l, d});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Producer driver: pops beats accepted on the previous edge, then presents queue heads.
    initial begin
        logic [3:0]  v;
        logic [3:0]  lst;
        logic [63:0] dat;
        logic [16:0] head;
        bif4.req_valid = '0;
        bif4.req_last  = '0;
        bif4.req_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            v   = '0;
            lst = '0;
            dat = '0;
            for (int i = 0; i < 4; i++) begin
                if (xfer4[i] && pq[i].size() > 0) begin
                    void'(pq[i].pop_front());
                end
                if (pq[i].size() > 0) begin
                    head          = pq[i][0];
                    v[i]          = 1'b1;
                    lst[i]        = head[16];
                    dat[i*16 +: 16] = head[15:0];
                end
            end
            bif4.req_valid = v;
            bif4.req_last  = lst;
            bif4.req_data  = dat;
        end
    end

    // Output monitor: scoreboard on every output transfer, stability while stalled.
    initial begin
        logic [18:0] held;
        logic [18:0] obs;
        logic        holding;
        holding = 1'b0;
        xfer4   = '0;
        forever begin
            @(posedge clk);
            #4;
            obs = {bif4.src_out, bif4.last_out, bif4.data_out};
            if (rst) begin
                xfer4   = '0;
                holding = 1'b0;
            end else begin
                xfer4 = bif4.req_valid & bif4.req_ready;
                if (holding && bif4.valid_out) begin
                    check("hold_stable", obs, held);
                end
                holding = 1'b0;
                if (bif4.valid_out && bif4.ready_out) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $error("FAIL out_beat: got %h expected none", obs);
                    end else begin
                        check("out_beat", obs, exp_q.pop_front());
                    end
                end else if (bif4.valid_out) begin
                    holding = 1'b1;
                    held    = obs;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        t2_grant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        rst            = 1'b1;
        bif4.ready_out = 1'b1;
        bif3.req_valid = '0;
        bif3.req_last  = '0;
        bif3.req_data  = '0;
        bif3.ready_out = 1'b1;

        // reset values
        cyc(2);
        #2;
        check("rst_valid_out", bif4.valid_out, 0);
        check("rst_data_out",  bif4.data_out, 0);
        check("rst_last_out",  bif4.last_out, 0);
        check("rst_src_out",   bif4.src_out, 0);
        check("rst_grant",     bif4.grant, 0);
        check("rst_busy",      bif4.busy, 0);
        check("rst_req_ready", bif4.req_ready, 0);
        check("rst3_grant",    bif3.grant, 0);
        cyc(1);
        rst = 1'b0;

        // single requester: req 2 sends A1,A2,A3
        cyc(1);
        push(2, 16'h00A1, 1'b0);
        push(2, 16'h00A2, 1'b0);
        push(2, 16'h00A3, 1'b1);
        expb(2, 1'b0, 16'h00A1);
        expb(2, 1'b0, 16'h00A2);
        expb(2, 1'b1, 16'h00A3);
        #2;
        check("t1_c0_grant", bif4.grant, 4'b0000);
        check("t1_c0_ready", bif4.req_ready, 4'b0000);
        cyc(1); #2;
        check("t1_c1_grant", bif4.grant, 4'b0100);
        check("t1_c1_ready", bif4.req_ready, 4'b0100);
        check("t1_c1_busy",  bif4.busy, 1);
        check("t1_c1_valid", bif4.valid_out, 0);
        cyc(1); #2;
        check("t1_c2_valid", bif4.valid_out, 1);
        check("t1_c2_data",  bif4.data_out, 16'h00A1);
        check("t1_c2_src",   bif4.src_out, 2);
        cyc(2); #2;
        check("t1_c4_grant", bif4.grant, 4'b0000);
        check("t1_c4_busy",  bif4.busy, 0);
        check("t1_c4_data",  bif4.data_out, 16'h00A3);
        check("t1_c4_last",  bif4.last_out, 1);
        cyc(1); #2;
        check("t1_c5_valid", bif4.valid_out, 0);
        check("t1_done", exp_q.size(), 0);

        // ptr is now 3: req 3 beats req 1
        cyc(1);
        push(1, 16'h00C1, 1'b1);
        push(3, 16'h00C3, 1'b1);
        expb(3, 1'b1, 16'h00C3);
        expb(1, 1'b1, 16'h00C1);
        cyc(1); #2;
        check("ptr3_grant", bif4.grant, 4'b1000);
        drain("ptr3_drain", 20);

        // reset in the middle of a grant with a beat held
        cyc(2);
        for (int k = 0; k < 4; k++) begin
            push(0, 16'h00D0 + 16'(k), 1'b0);
        end
        cyc(2);
        check("rstg_pre_valid", bif4.valid_out, 1);
        check("rstg_pre_busy",  bif4.busy, 1);
        rst = 1'b1;
        pq[0].delete();
        #2;
        check("rstg_valid_out", bif4.valid_out, 0);
        check("rstg_data_out",  bif4.data_out, 0);
        check("rstg_src_out",   bif4.src_out, 0);
        check("rstg_grant",     bif4.grant, 0);
        check("rstg_busy",      bif4.busy, 0);
        check("rstg_req_ready", bif4.req_ready, 0);
        cyc(2);
        rst = 1'b0;

        // all four requesters, one-beat packets, arbitration from ptr 0
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            push(i, 16'h00B0 + 16'(i), 1'b1);
        end
        push(0, 16'h00B4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expb(i, 1'b1, 16'h00B0 + 16'(i));
        end
        expb(0, 1'b1, 16'h00B4);
        #2;
        check("t2_c0_grant", bif4.grant, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            cyc(1); #2;
            check("t2_grant_seq", bif4.grant, t2_grant[k]);
        end
        drain("t2_drain", 20);

        // burst limit: req 1 streams 20 beats without last, req 3 has a 2-beat packet
        cyc(1);
        for (int k = 0; k < 20; k++) begin
            push(1, 16'h0100 + 16'(k), 1'b0);
        end
        push(3, 16'h0300, 1'b0);
        push(3, 16'h0301, 1'b1);
        for (int k = 0; k < 8; k++) begin
            expb(1, 1'b0, 16'h0100 + 16'(k));
        end
        expb(3, 1'b0, 16'h0300);
        expb(3, 1'b1, 16'h0301);
        for (int k = 8; k < 20; k++) begin
            expb(1, 1'b0, 16'h0100 + 16'(k));
        end
        cyc(1); #2;
        check("burst_first_grant", bif4.grant, 4'b0010);
        drain("burst_drain", 80);
        cyc(2); #2;
        check("burst_held_grant", bif4.grant, 4'b0010);
        check("burst_held_busy",  bif4.busy, 1);
        check("burst_held_ready", bif4.req_ready, 4'b0010);
        cyc(1);
        push(1, 16'h01FF, 1'b1);
        expb(1, 1'b1, 16'h01FF);
        drain("burst_close_drain", 20);
        cyc(2); #2;
        check("burst_end_grant", bif4.grant, 4'b0000);

        // backpressure mid-packet on req 2
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            push(2, 16'h0200 + 16'(k), (k == 5));
            expb(2, (k == 5), 16'h0200 + 16'(k));
        end
        cyc(3);
        bif4.ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("bp_valid", bif4.valid_out, 1);
            check("bp_data",  bif4.data_out, 16'h0201);
            check("bp_src",   bif4.src_out, 2);
            check("bp_ready", bif4.req_ready, 4'b0000);
            check("bp_grant", bif4.grant, 4'b0100);
            cyc(1);
        end
        bif4.ready_out = 1'b1;
        drain("bp_drain", 30);

        // NUM_REQ=3, MAX_BURST=1: pointer wrap and beat interleave
        cyc(1);
        bif3.req_valid = 3'b100;
        bif3.req_last  = 3'b100;
        bif3.req_data  = {16'h0022, 16'h0000, 16'h0000};
        cyc(1); #2;
        check("w3_c1_grant", bif3.grant, 3'b100);
        check("w3_c1_ready", bif3.req_ready, 3'b100);
        cyc(1);
        bif3.req_valid = 3'b101;
        bif3.req_last  = 3'b000;
        bif3.req_data  = {16'h0023, 16'h0000, 16'h0010};
        #2;
        check("w3_c2_valid", bif3.valid_out, 1);
        check("w3_c2_data",  bif3.data_out, 16'h0022);
        check("w3_c2_src",   bif3.src_out, 2);
        check("w3_c2_grant", bif3.grant, 3'b000);
        cyc(1); #2;
        check("w3_c3_grant", bif3.grant, 3'b001);
        cyc(1); #2;
        check("w3_c4_grant", bif3.grant, 3'b000);
        check("w3_c4_src",   bif3.src_out, 0);
        check("w3_c4_data",  bif3.data_out, 16'h0010);
        cyc(1); #2;
        check("w3_c5_grant", bif3.grant, 3'b100);
        cyc(1); #2;
        check("w3_c6_grant", bif3.grant, 3'b000);
        check("w3_c6_src",   bif3.src_out, 2);
        check("w3_c6_data",  bif3.data_out, 16'h0023);
        cyc(1); #2;
        check("w3_c7_grant", bif3.grant, 3'b001);
        bif3.req_valid = '0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
